gcd_operand_fifo: RTL and testbench

Parameterised val/rdy queue of GCD operand pairs (A,B), sitting directly upstream of gcd_coprocessor. Enqueue side faces the request source (host/test driver). Dequeue side connects 1:1 to the coprocessor's operands_val/operands_rdy/operands_bits_A/operands_bits_B. Decouples bursty request issue from the coprocessor's variable iteration latency; strict FIFO order, no reordering.

---
 rtl/gcd_pkg.sv | 18 +
 rtl/gcd_fifo_mem.sv | 35 +++
 rtl/gcd_operand_fifo.sv | 83 ++++++++
 tb/tb_gcd_operand_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg
// Shared definitions for the GCD request path: the default operand width,
// the operand-pair record, and the width helper for occupancy counters.
package gcd_pkg;

    localparam int GCD_W = 16;

    typedef struct packed {
        logic [GCD_W-1:0] A;
        logic [GCD_W-1:0] B;
    } operand_pair_t;

    // An occupancy counter must represent 0..depth inclusive, hence the +1.
    function automatic int fifo_count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/gcd_fifo_mem.sv
// gcd_fifo_mem
// DEPTH x DW register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//
// Ports:
//   clk      clock
//   wr_en    write strobe, sampled on posedge clk
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address (combinational read)
//   rd_data  data stored at rd_addr
module gcd_fifo_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/gcd_operand_fifo.sv
// gcd_operand_fifo
// Val/rdy queue of GCD operand pairs (A,B) feeding gcd_coprocessor. Strict
// FIFO order, no full-bypass and no empty-bypass, so enq_rdy and deq_val are
// functions of the registered count (and reset) only.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   enq_val/enq_rdy          producer handshake
//   enq_bits_A/enq_bits_B    incoming operand pair
//   deq_val/deq_rdy          consumer handshake (coprocessor operands_val/rdy)
//   deq_bits_A/deq_bits_B    head operand pair
//   count                    current occupancy, 0..DEPTH
module gcd_operand_fifo
    import gcd_pkg::*;
#(
    parameter int W     = GCD_W,
    parameter int DEPTH = 4,
    localparam int CW   = fifo_count_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enq_val,
    input  logic [W-1:0]  enq_bits_A,
    input  logic [W-1:0]  enq_bits_B,
    output logic          enq_rdy,
    output logic          deq_val,
    output logic [W-1:0]  deq_bits_A,
    output logic [W-1:0]  deq_bits_B,
    input  logic          deq_rdy,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           enq_fire;
    logic           deq_fire;
    logic [2*W-1:0] head;

    // Reset masks both handshakes so nothing fires on a reset edge.
    assign enq_rdy  = (count != FULL_COUNT) & ~reset;
    assign deq_val  = (count != '0) & ~reset;
    assign enq_fire = enq_val & enq_rdy;
    assign deq_fire = deq_val & deq_rdy;

    gcd_fifo_mem #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (enq_fire),
        .wr_addr (wr_ptr),
        .wr_data ({enq_bits_A, enq_bits_B}),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    assign {deq_bits_A, deq_bits_B} = head;

    // DEPTH is a power of two, so pointers wrap naturally at PW bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_operand_fifo.sv
// tb_gcd_operand_fifo
// Self-checking bench for gcd_operand_fifo. A queue of expected pairs is
// updated on every clock edge from the bench's own view of the handshakes;
// each test task compares DUT outputs against that queue and constants.
module tb_gcd_operand_fifo;
    import gcd_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int CW    = fifo_count_width(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic          enq_val;
    logic [W-1:0]  enq_bits_A;
    logic [W-1:0]  enq_bits_B;
    logic          enq_rdy;
    logic          deq_val;
    logic [W-1:0]  deq_bits_A;
    logic [W-1:0]  deq_bits_B;
    logic          deq_rdy;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    operand_pair_t exp_q[$];

    always #5 clk = ~clk;

    gcd_operand_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .enq_val    (enq_val),
        .enq_bits_A (enq_bits_A),
        .enq_bits_B (enq_bits_B),
        .enq_rdy    (enq_rdy),
        .deq_val    (deq_val),
        .deq_bits_A (deq_bits_A),
        .deq_bits_B (deq_bits_B),
        .deq_rdy    (deq_rdy),
        .count      (count)
    );

    // Advance one clock edge, updating the expected queue from the inputs
    // as they stood at that edge. Returns 1 time unit after the edge.
    task automatic cycle();
        bit enq_f;
        bit deq_f;
        operand_pair_t p;
        enq_f = !reset && enq_val && (exp_q.size() < DEPTH);
        deq_f = !reset && deq_rdy && (exp_q.size() > 0);
        p = operand_pair_t'({enq_bits_A, enq_bits_B});
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
        end else begin
            if (deq_f) void'(exp_q.pop_front());
            if (enq_f) exp_q.push_back(p);
        end
        #1;
    endtask

    task automatic push_pair(input int a, input int b);
        enq_val    = 1'b1;
        enq_bits_A = W'(a);
        enq_bits_B = W'(b);
        cycle();
        enq_val    = 1'b0;
    endtask

    function automatic int gcd_ref(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic test_reset();
        reset = 1'b1; enq_val = 1'b0; deq_rdy = 1'b0;
        enq_bits_A = '0; enq_bits_B = '0;
        repeat (5) cycle();
        total++; if (count !== '0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        total++; if (enq_rdy !== 1'b0) begin bad++; $display("[TB] FAIL reset_enq_rdy: got %b expected 0", enq_rdy); end
        total++; if (deq_val !== 1'b0) begin bad++; $display("[TB] FAIL reset_deq_val: got %b expected 0", deq_val); end
        reset = 1'b0;
        cycle();
        total++; if (enq_rdy !== 1'b1) begin bad++; $display("[TB] FAIL idle_enq_rdy: got %b expected 1", enq_rdy); end
        total++; if (deq_val !== 1'b0) begin bad++; $display("[TB] FAIL idle_deq_val: got %b expected 0", deq_val); end
        total++; if (count !== '0) begin bad++; $display("[TB] FAIL idle_count: got %0d expected 0", count); end
        // deq_rdy on an empty queue must be ignored
        deq_rdy = 1'b1;
        cycle();
        total++; if (count !== '0) begin bad++; $display("[TB] FAIL empty_deq_count: got %0d expected 0", count); end
        total++; if (deq_val !== 1'b0) begin bad++; $display("[TB] FAIL empty_deq_val: got %b expected 0", deq_val); end
        deq_rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        push_pair(5, 6);
        push_pair(7, 8);
        total++; if (count !== CW'(2)) begin bad++; $display("[TB] FAIL mid_pre_count: got %0d expected 2", count); end
        reset = 1'b1;
        cycle();
        total++; if (count !== '0) begin bad++; $display("[TB] FAIL mid_reset_count: got %0d expected 0", count); end
        total++; if (deq_val !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_deq_val: got %b expected 0", deq_val); end
        reset = 1'b0;
        cycle();
        total++; if (deq_val !== 1'b0 || enq_rdy !== 1'b1 || count !== '0) begin
            bad++; $display("[TB] FAIL mid_after_reset: got val=%b rdy=%b count=%0d expected 0 1 0", deq_val, enq_rdy, count);
        end
    endtask

    task automatic test_single_stall();
        push_pair(27, 15);
        total++; if (count !== CW'(1)) begin bad++; $display("[TB] FAIL single_count: got %0d expected 1", count); end
        for (int i = 0; i < 3; i++) begin
            total++; if (deq_val !== 1'b1 || deq_bits_A !== W'(27) || deq_bits_B !== W'(15)) begin
                bad++; $display("[TB] FAIL single_stall_%0d: got val=%b (%0d,%0d) expected 1 (27,15)", i, deq_val, deq_bits_A, deq_bits_B);
            end
            cycle();
        end
        deq_rdy = 1'b1;
        cycle();
        deq_rdy = 1'b0;
        total++; if (count !== '0) begin bad++; $display("[TB] FAIL single_drain_count: got %0d expected 0", count); end
    endtask

    task automatic test_full();
        int ea[3] = '{12, 200, 15};
        int eb[3] = '{8, 35, 9};
        push_pair(27, 15); push_pair(12, 8); push_pair(200, 35); push_pair(15, 9);
        total++; if (count !== CW'(4)) begin bad++; $display("[TB] FAIL full_count: got %0d expected 4", count); end
        total++; if (enq_rdy !== 1'b0) begin bad++; $display("[TB] FAIL full_enq_rdy: got %b expected 0", enq_rdy); end
        enq_val = 1'b1; enq_bits_A = W'(99); enq_bits_B = W'(36);
        cycle();
        total++; if (count !== CW'(4)) begin bad++; $display("[TB] FAIL full_reject_count: got %0d expected 4", count); end
        // enq and deq together while full: only the dequeue may fire
        deq_rdy = 1'b1;
        cycle();
        enq_val = 1'b0;
        total++; if (count !== CW'(3)) begin bad++; $display("[TB] FAIL full_both_count: got %0d expected 3", count); end
        for (int k = 0; k < 3; k++) begin
            total++; if (deq_val !== 1'b1 || deq_bits_A !== W'(ea[k]) || deq_bits_B !== W'(eb[k]) ||
                         operand_pair_t'({deq_bits_A, deq_bits_B}) !== exp_q[0]) begin
                bad++; $display("[TB] FAIL full_drain_%0d: got (%0d,%0d) expected (%0d,%0d)", k, deq_bits_A, deq_bits_B, ea[k], eb[k]);
            end
            cycle();
        end
        deq_rdy = 1'b0;
        total++; if (count !== '0 || deq_val !== 1'b0) begin bad++; $display("[TB] FAIL full_end: got count=%0d val=%b expected 0 0", count, deq_val); end
    endtask

    task automatic test_drain();
        int ea[4] = '{27, 12, 200, 15};
        int eb[4] = '{15, 8, 35, 9};
        for (int k = 0; k < 4; k++) push_pair(ea[k], eb[k]);
        deq_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++; if (count !== CW'(4 - k)) begin bad++; $display("[TB] FAIL drain_count_%0d: got %0d expected %0d", k, count, 4 - k); end
            total++; if (deq_val !== 1'b1 || deq_bits_A !== W'(ea[k]) || deq_bits_B !== W'(eb[k])) begin
                bad++; $display("[TB] FAIL drain_pair_%0d: got val=%b (%0d,%0d) expected 1 (%0d,%0d)", k, deq_val, deq_bits_A, deq_bits_B, ea[k], eb[k]);
            end
            cycle();
        end
        deq_rdy = 1'b0;
        total++; if (count !== '0 || deq_val !== 1'b0) begin bad++; $display("[TB] FAIL drain_end: got count=%0d val=%b expected 0 0", count, deq_val); end
    endtask

    task automatic test_back_to_back();
        deq_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                total++; if (deq_val !== 1'b1 || deq_bits_A !== W'(i - 1) || deq_bits_B !== W'(i) ||
                             operand_pair_t'({deq_bits_A, deq_bits_B}) !== exp_q[0]) begin
                    bad++; $display("[TB] FAIL stream_pair_%0d: got (%0d,%0d) expected (%0d,%0d)", i - 1, deq_bits_A, deq_bits_B, i - 1, i);
                end
            end
            enq_val = 1'b1; enq_bits_A = W'(i); enq_bits_B = W'(i + 1);
            cycle();
            total++; if (count !== CW'(1)) begin bad++; $display("[TB] FAIL stream_count_%0d: got %0d expected 1", i, count); end
        end
        enq_val = 1'b0;
        total++; if (deq_val !== 1'b1 || deq_bits_A !== W'(9) || deq_bits_B !== W'(10)) begin
            bad++; $display("[TB] FAIL stream_last: got (%0d,%0d) expected (9,10)", deq_bits_A, deq_bits_B);
        end
        cycle();
        deq_rdy = 1'b0;
        total++; if (count !== '0) begin bad++; $display("[TB] FAIL stream_end_count: got %0d expected 0", count); end
    endtask

    task automatic test_gcd_burst();
        int pa[7]  = '{27, 12, 200, 15, 99, 1, 144};
        int pb[7]  = '{15, 8, 35, 9, 36, 2, 168};
        int res[7] = '{3, 4, 5, 3, 9, 1, 24};
        int exp_res[$];
        int sent = 0;
        int got  = 0;
        int g;
        for (int cyc = 0; cyc < 300 && got < 7; cyc++) begin
            deq_rdy = ($urandom_range(0, 3) != 0);
            enq_val = (sent < 7);
            if (sent < 7) begin
                enq_bits_A = W'(pa[sent]);
                enq_bits_B = W'(pb[sent]);
            end
            if (deq_rdy && exp_q.size() > 0) begin
                g = gcd_ref(int'(deq_bits_A), int'(deq_bits_B));
                total++; if (deq_val !== 1'b1 || operand_pair_t'({deq_bits_A, deq_bits_B}) !== exp_q[0] || g != exp_res[0]) begin
                    bad++; $display("[TB] FAIL gcd_result_%0d: got (%0d,%0d) gcd %0d expected (%0d,%0d) gcd %0d",
                                    got, deq_bits_A, deq_bits_B, g, exp_q[0].A, exp_q[0].B, exp_res[0]);
                end
                void'(exp_res.pop_front());
                got++;
            end
            if (enq_val && exp_q.size() < DEPTH) begin
                exp_res.push_back(res[sent]);
                sent++;
            end
            cycle();
        end
        enq_val = 1'b0;
        deq_rdy = 1'b0;
        total++; if (got != 7 || count !== '0) begin bad++; $display("[TB] FAIL gcd_burst_done: got %0d results count=%0d expected 7 results count=0", got, count); end
    endtask

    initial begin
        $display("[TB] starting gcd_operand_fifo tests");
        test_reset();
        test_reset_mid();
        test_single_stall();
        test_full();
        test_drain();
        test_back_to_back();
        test_gcd_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
